// File: rtl/hit_detector_pkg.sv
// hit_detector_pkg: shared game constants (asteroid size codes, point values)
// and the detector FSM state type. The score block imports the same constants.
// Contents: ast_size_e, PTS_* values, det_state_e, size_points().
package hit_detector_pkg;

    // Asteroid size codes as stored in the slot table.
    typedef enum logic [1:0] {
        SZ_LARGE  = 2'd0,
        SZ_MEDIUM = 2'd1,
        SZ_SMALL  = 2'd2,
        SZ_RSVD   = 2'd3
    } ast_size_e;

    localparam logic [9:0] PTS_LARGE  = 10'd20;
    localparam logic [9:0] PTS_MEDIUM = 10'd50;
    localparam logic [9:0] PTS_SMALL  = 10'd100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CMP   = 3'd2,
        ST_HIT   = 3'd3,
        ST_DONE  = 3'd4
    } det_state_e;

    // Reserved size code scores nothing; it is also never treated as a hit.
    function automatic logic [9:0] size_points(input logic [1:0] sz);
        logic [9:0] pts;
        case (sz)
            SZ_LARGE:  pts = PTS_LARGE;
            SZ_MEDIUM: pts = PTS_MEDIUM;
            SZ_SMALL:  pts = PTS_SMALL;
            default:   pts = 10'd0;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/hit_detector_if.sv
// hit_detector_if: bundle of the detector's bullet inputs, slot-table read
// port and collision outputs. master = detector, slave = surrounding logic.
// Ports: none (signal container); parameters size the coordinate/index fields.
interface hit_detector_if #(
    parameter int N_AST = 8,
    parameter int X_W   = 10,
    parameter int Y_W   = 9
);
    localparam int A_W = $clog2(N_AST);

    // Bullet side
    logic           frame_tick;
    logic           bullet_active;
    logic [X_W-1:0] bullet_x;
    logic [Y_W-1:0] bullet_y;

    // Slot table synchronous read port (data 1 cycle after address)
    logic [A_W-1:0] ast_addr;
    logic           ast_valid;
    logic [X_W-1:0] ast_x;
    logic [Y_W-1:0] ast_y;
    logic [1:0]     ast_size;

    // Collision results towards the score block
    logic           hit;
    logic [9:0]     hit_points;
    logic [A_W-1:0] kill_idx;
    logic           bullet_clear;
    logic           busy;
    logic           scan_done;

    modport master (
        input  frame_tick, bullet_active, bullet_x, bullet_y,
        input  ast_valid, ast_x, ast_y, ast_size,
        output ast_addr,
        output hit, hit_points, kill_idx, bullet_clear, busy, scan_done
    );

    modport slave (
        output frame_tick, bullet_active, bullet_x, bullet_y,
        output ast_valid, ast_x, ast_y, ast_size,
        input  ast_addr,
        input  hit, hit_points, kill_idx, bullet_clear, busy, scan_done
    );

endinterface

// File: rtl/hit_detector_box_overlap.sv
// box_overlap: combinational axis-aligned box overlap test between two centres.
// Ports: a_x_i/a_y_i, b_x_i/b_y_i centres; half_sum_i inclusive bound; overlap_o.
// Latency 0; no flow control.
module box_overlap
    import hit_detector_pkg::*;
#(
    parameter int X_W = 10,
    parameter int Y_W = 9,
    parameter int CW  = ((X_W > Y_W) ? X_W : Y_W) + 1
) (
    input  logic [X_W-1:0] a_x_i,
    input  logic [Y_W-1:0] a_y_i,
    input  logic [X_W-1:0] b_x_i,
    input  logic [Y_W-1:0] b_y_i,
    input  logic [CW-1:0]  half_sum_i,
    output logic           overlap_o
);

    // Differences carry one extra sign bit so screen edges never wrap.
    logic signed [X_W:0] dx;
    logic signed [Y_W:0] dy;
    logic        [X_W:0] adx;
    logic        [Y_W:0] ady;

    always_comb begin
        dx  = $signed({1'b0, a_x_i}) - $signed({1'b0, b_x_i});
        dy  = $signed({1'b0, a_y_i}) - $signed({1'b0, b_y_i});
        // Magnitude of a (W+1)-bit difference of W-bit values fits in W+1 bits.
        adx = dx[X_W] ? $unsigned(-dx) : $unsigned(dx);
        ady = dy[Y_W] ? $unsigned(-dy) : $unsigned(dy);
        overlap_o = (CW'(adx) <= half_sum_i) && (CW'(ady) <= half_sum_i);
    end

endmodule

// File: rtl/hit_detector.sv
// hit_detector: per-frame bullet/asteroid collision scan over the slot table.
// Ports: clk, reset (sync, active-high), bus (hit_detector_if.master).
// Latency: slot k compared 2+2k cycles after tick; hit 1 cycle later. No backpressure; ticks while busy are dropped.
module hit_detector
    import hit_detector_pkg::*;
#(
    parameter int N_AST    = 8,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int AST_HALF = 8,
    parameter int BUL_HALF = 1
) (
    input  logic            clk,
    input  logic            reset,
    hit_detector_if.master  bus
);

    localparam int A_W = $clog2(N_AST);
    localparam int CW  = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam logic [CW-1:0]  HALF_SUM = CW'(AST_HALF + BUL_HALF);
    localparam logic [A_W-1:0] IDX_LAST = A_W'(N_AST - 1);

    det_state_e     state_q;
    logic [A_W-1:0] idx_q;
    logic [A_W-1:0] idx_d;
    logic [X_W-1:0] bx_q;
    logic [Y_W-1:0] by_q;
    logic [A_W-1:0] ast_addr_q;
    logic           hit_q;
    logic [9:0]     pts_q;
    logic [A_W-1:0] kill_q;
    logic           busy_q;
    logic           done_q;

    logic           overlap;
    logic           slot_hit_d;

    box_overlap #(
        .X_W (X_W),
        .Y_W (Y_W),
        .CW  (CW)
    ) u_overlap (
        .a_x_i      (bus.ast_x),
        .a_y_i      (bus.ast_y),
        .b_x_i      (bx_q),
        .b_y_i      (by_q),
        .half_sum_i (HALF_SUM),
        .overlap_o  (overlap)
    );

    // Read data is only meaningful in CMP; the FSM ignores it elsewhere.
    always_comb begin
        idx_d      = idx_q + 1'b1;
        slot_hit_d = bus.ast_valid && (bus.ast_size != SZ_RSVD) && overlap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            ast_addr_q <= '0;
            hit_q      <= 1'b0;
            pts_q      <= '0;
            kill_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Pulse outputs default low; hit payload reads 0 outside the hit cycle.
            hit_q  <= 1'b0;
            pts_q  <= '0;
            kill_q <= '0;
            done_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (bus.frame_tick) begin
                        bx_q  <= bus.bullet_x;
                        by_q  <= bus.bullet_y;
                        idx_q <= '0;
                        if (bus.bullet_active) begin
                            state_q    <= ST_FETCH;
                            ast_addr_q <= '0;
                            busy_q     <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end

                ST_FETCH: begin
                    state_q <= ST_CMP;
                end

                ST_CMP: begin
                    if (slot_hit_d) begin
                        state_q <= ST_HIT;
                        hit_q   <= 1'b1;
                        kill_q  <= idx_q;
                        pts_q   <= size_points(bus.ast_size);
                    end else if (idx_q == IDX_LAST) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= ST_FETCH;
                        idx_q      <= idx_d;
                        ast_addr_q <= idx_d;
                    end
                end

                ST_HIT: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ast_addr     = ast_addr_q;
    assign bus.hit          = hit_q;
    assign bus.bullet_clear = hit_q;
    assign bus.hit_points   = pts_q;
    assign bus.kill_idx     = kill_q;
    assign bus.busy         = busy_q;
    assign bus.scan_done    = done_q;

endmodule

// File: tb/tb_hit_detector.sv
// tb_hit_detector: scoreboard bench for hit_detector with a slot-table memory
// model, directed scenarios and randomized scans checked by a reference model.
module tb_hit_detector;

    localparam int N   = 8;
    localparam int XW  = 10;
    localparam int YW  = 9;
    localparam int LIM = 9;   // asteroid half 8 + bullet half 1

    typedef struct {
        bit is_hit;
        int cyc;
        int idx;
        int pts;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    logic [XW-1:0] mx[N];
    logic [YW-1:0] my[N];
    logic          mv[N];
    logic [1:0]    ms[N];

    hit_detector_if #(.N_AST(N), .X_W(XW), .Y_W(YW)) bus ();

    hit_detector #(
        .N_AST(N), .X_W(XW), .Y_W(YW), .AST_HALF(8), .BUL_HALF(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slot table: synchronous read, data one cycle after the address.
    always @(posedge clk) begin
        bus.ast_valid <= mv[bus.ast_addr];
        bus.ast_x     <= mx[bus.ast_addr];
        bus.ast_y     <= my[bus.ast_addr];
        bus.ast_size  <= ms[bus.ast_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: first occupied, non-reserved slot within the inclusive box.
    function automatic int first_hit(input int bx, input int by);
        for (int i = 0; i < N; i++) begin
            int dx = int'(mx[i]) - bx;
            int dy = int'(my[i]) - by;
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            if (mv[i] && ms[i] != 2'd3 && dx <= LIM && dy <= LIM) return i;
        end
        return -1;
    endfunction

    function automatic int points_of(input logic [1:0] sz);
        case (sz)
            2'd0:    return 20;
            2'd1:    return 50;
            2'd2:    return 100;
            default: return 0;
        endcase
    endfunction

    function automatic exp_t mk(input bit h, input int c, input int i, input int p);
        exp_t e;
        e.is_hit = h; e.cyc = c; e.idx = i; e.pts = p;
        return e;
    endfunction

    // Monitor: every hit / scan_done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (!bus.hit) chk("points_zero_idle", 32'(bus.hit_points), 32'd0);
            if (bus.hit || bus.scan_done || bus.bullet_clear) begin
                chk("clear_with_hit", 32'(bus.bullet_clear), 32'(bus.hit));
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {30'd0, bus.hit, bus.scan_done}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("event_kind_hit", 32'(bus.hit), 32'(e.is_hit));
                    chk("event_kind_done", 32'(bus.scan_done), 32'(!e.is_hit));
                    chk("event_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.is_hit) begin
                        chk("kill_idx", 32'(bus.kill_idx), 32'(e.idx));
                        chk("hit_points", 32'(bus.hit_points), 32'(e.pts));
                    end
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0; mx[i] = '0; my[i] = '0; ms[i] = 2'd0;
        end
    endtask

    task automatic set_slot(input int i, input int x, input int y, input int sz);
        mv[i] = 1'b1; mx[i] = XW'(x); my[i] = YW'(y); ms[i] = 2'(sz);
    endtask

    // Issue one tick, push the model's expected events, then scramble the
    // bullet inputs every cycle until the scan's events have all been seen.
    task automatic run_scan(input bit act, input int x, input int y, input bit extra_tick);
        int t, k, n;
        @(posedge clk); #1;
        bus.bullet_active = act;
        bus.bullet_x      = XW'(x);
        bus.bullet_y      = YW'(y);
        bus.frame_tick    = 1'b1;
        t = cyc;
        k = act ? first_hit(x, y) : -1;
        if (!act) begin
            exp_q.push_back(mk(1'b0, t + 1, 0, 0));
        end else if (k >= 0) begin
            exp_q.push_back(mk(1'b1, t + 3 + 2 * k, k, points_of(ms[k])));
            exp_q.push_back(mk(1'b0, t + 4 + 2 * k, 0, 0));
        end else begin
            exp_q.push_back(mk(1'b0, t + 1 + 2 * N, 0, 0));
        end
        n = 0;
        while (exp_q.size() != 0 && n < 2 * N + 10) begin
            @(posedge clk); #1;
            n++;
            bus.frame_tick    = extra_tick && (n == 2);
            bus.bullet_x      = XW'($urandom_range(0, 639));
            bus.bullet_y      = YW'($urandom_range(0, 479));
            bus.bullet_active = 1'($urandom_range(0, 1));
            if (n == 1) chk("busy_after_tick", 32'(bus.busy), 32'(act));
            if (!act) chk("busy_inactive", 32'(bus.busy), 32'd0);
        end
        bus.frame_tick = 1'b0;
        if (exp_q.size() != 0) begin
            chk("scan_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        int t;
        bus.frame_tick = 1'b0;
        bus.bullet_active = 1'b0;
        bus.bullet_x = '0;
        bus.bullet_y = '0;
        clear_mem();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hit", 32'(bus.hit), 32'd0);
        chk("rst_done", 32'(bus.scan_done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_clear", 32'(bus.bullet_clear), 32'd0);
        chk("rst_points", 32'(bus.hit_points), 32'd0);
        chk("rst_kill", 32'(bus.kill_idx), 32'd0);
        chk("rst_addr", 32'(bus.ast_addr), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Inactive bullet: done at T+1, never busy
        run_scan(1'b0, 100, 100, 1'b0);

        // Slot 3 small near bullet
        clear_mem();
        set_slot(3, 108, 91, 2);
        run_scan(1'b1, 100, 100, 1'b0);

        // Just outside vs exactly on the bound
        clear_mem();
        set_slot(0, 110, 100, 0);
        set_slot(5, 109, 109, 0);
        run_scan(1'b1, 100, 100, 1'b0);

        // No toroidal wrap at screen edge
        clear_mem();
        set_slot(1, 639, 0, 0);
        set_slot(2, 5, 3, 1);
        run_scan(1'b1, 0, 0, 1'b0);

        // Two overlapping slots, plus a tick while busy
        clear_mem();
        set_slot(1, 300, 200, 0);
        set_slot(4, 302, 198, 2);
        run_scan(1'b1, 301, 199, 1'b1);

        // Reserved size and empty slot are skipped; miss on every slot
        clear_mem();
        set_slot(0, 50, 50, 3);
        mv[2] = 1'b0; mx[2] = 10'd50; my[2] = 9'd50;
        set_slot(6, 55, 45, 2);
        run_scan(1'b1, 50, 50, 1'b0);
        clear_mem();
        set_slot(7, 400, 400, 1);
        run_scan(1'b1, 390, 400, 1'b0);
        run_scan(1'b1, 638, 478, 1'b0);

        // Reset in the middle of a hitting scan
        clear_mem();
        set_slot(3, 108, 91, 2);
        @(posedge clk); #1;
        bus.bullet_active = 1'b1;
        bus.bullet_x = 10'd100;
        bus.bullet_y = 9'd100;
        bus.frame_tick = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        while (cyc < t + 6) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_hit", 32'(bus.hit), 32'd0);
        chk("midrst_done", 32'(bus.scan_done), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_addr", 32'(bus.ast_addr), 32'd0);
        reset = 1'b0;
        repeat (2 * N + 4) @(posedge clk);
        run_scan(1'b1, 100, 100, 1'b0);

        // Randomized scans against the reference model
        for (int r = 0; r < 60; r++) begin
            int bx, by;
            for (int i = 0; i < N; i++) begin
                mv[i] = ($urandom_range(0, 9) < 6);
                mx[i] = XW'($urandom_range(0, 60));
                my[i] = YW'($urandom_range(0, 60));
                ms[i] = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) mx[$urandom_range(0, N - 1)] = 10'd639;
            bx = $urandom_range(0, 60);
            by = $urandom_range(0, 60);
            run_scan($urandom_range(0, 7) != 0, bx, by, $urandom_range(0, 3) == 0);
        end

        // Idle tail: any stray pulse is flagged by the monitor
        repeat (40) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
